// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants, types and helpers for the RAM port arbiter
package ram_arb_pkg;
  localparam int BE_WIDTH = 4;
  // The structs use fixed maximum widths so they can live in the package.
  // The top casts its parameterised ports into and out of these fields.
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W = 8;
  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                we;
    logic [BE_WIDTH-1:0] be;
    logic [DATA_W-1:0]   wdata;
  } ram_req_t;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            we;
  } resp_state_t;
endpackage

// File: rtl/ram_arb_rr.sv
// ram_arb_rr: combinational round-robin pick of the first request at or after ptr_i
module ram_arb_rr
  import ram_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  // Rotate the request vector so ptr_i sits at bit 0, then take the lowest set bit.
  always_comb begin
    dbl = {req_i, req_i};
    rot = dbl[ptr_i +: N];
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    sum = {1'b0, ptr_i} + {1'b0, off};
    idx_o = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
    gnt_o = (|req_i) ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one byte-enabled RAM port among NUM_REQ requesters
// Define RAM_ARB_STATS_EN to add per-requester saturating wait counters (stat_wait_o, stat_clr_i).
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ*BE_WIDTH-1:0]   be_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
`ifdef RAM_ARB_STATS_EN
  input  logic                          stat_clr_i,
  output logic [NUM_REQ*32-1:0]         stat_wait_o,
`endif
  output logic                          ram_en_o,
  output logic [ADDR_WIDTH-1:0]         ram_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_wdata_o,
  output logic                          ram_we_o,
  output logic [BE_WIDTH-1:0]           ram_be_o,
  input  logic [DATA_WIDTH-1:0]         ram_rdata_i
);
  localparam int IW = idx_w(NUM_REQ);
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      idx;
  logic [NUM_REQ-1:0] gnt;
  logic               any;
  ram_req_t           sel;
  resp_state_t        resp_q;
  assign any = |req_i;
  ram_arb_rr #(.N(NUM_REQ)) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (idx)
  );
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel.addr  = ADDR_W'(addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
        sel.we    = we_i[i];
        sel.be    = be_i[i*BE_WIDTH +: BE_WIDTH];
        sel.wdata = DATA_W'(wdata_i[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end
  assign gnt_o       = gnt;
  assign ram_en_o    = any;
  assign ram_addr_o  = ADDR_WIDTH'(sel.addr);
  assign ram_wdata_o = DATA_WIDTH'(sel.wdata);
  assign ram_we_o    = sel.we;
  assign ram_be_o    = sel.be;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      resp_q <= '0;
    end else begin
      ptr_q        <= any ? ((idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1) : ptr_q;
      resp_q.valid <= any;
      resp_q.id    <= ID_W'(idx);
      resp_q.we    <= sel.we;
    end
  end
  // Writes still answer with rvalid so every requester sees one response per grant.
  assign rvalid_o = resp_q.valid ? NUM_REQ'(1) << resp_q.id : '0;
  assign rdata_o  = (resp_q.valid && !resp_q.we) ? ram_rdata_i : '0;
`ifdef RAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] wait_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wait_q <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        wait_q[i] <= stat_clr_i ? '0 :
                     (req_i[i] && !gnt[i] && wait_q[i] != '1) ? wait_q[i] + 32'd1 : wait_q[i];
  end
  assign stat_wait_o = wait_q;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed table-driven bench for ram_port_arbiter with a byte-enabled RAM model
module tb_ram_port_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, we, gnt, rvalid;
  logic [127:0] addr, wdata;
  logic [15:0]  be;
  logic [31:0]  rdata, ram_addr, ram_wdata, ram_rdata;
  logic         ram_en, ram_we;
  logic [3:0]   ram_be;
  logic [31:0]  mem [0:255];
  int           total = 0;
  int           bad = 0;
`ifdef RAM_ARB_STATS_EN
  logic         stat_clr;
  logic [127:0] stat_wait;
`endif
  always #5 clk = ~clk;
  ram_port_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
`ifdef RAM_ARB_STATS_EN
    .stat_clr_i  (stat_clr),
    .stat_wait_o (stat_wait),
`endif
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_rdata_i (ram_rdata)
  );
  // RAM model: registered read, byte-enabled write, word index from addr[9:2]
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'h0;
    end else if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else ram_rdata <= mem[ram_addr[9:2]];
    end
  end
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  exp_gnt;
    logic [3:0]  exp_rv;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask
  // Requester i sees addr | (i<<12); the RAM ignores those high bits, the mux check does not.
  task automatic drive(input logic [3:0] r, input logic [3:0] w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    @(negedge clk);
    req = r;
    we  = w;
    for (int i = 0; i < 4; i++) begin
      addr[i*32 +: 32]  = a | (32'(i) << 12);
      be[i*4 +: 4]      = b;
      wdata[i*32 +: 32] = d;
    end
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask
  function automatic int win(input logic [3:0] g);
    int w = 0;
    for (int i = 0; i < 4; i++) if (g[i]) w = i;
    return w;
  endfunction
  initial begin
    int cnt [4];
    logic [31:0] ea;
    vecs[0]  = '{4'b0001, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b0001, 4'b0000, 32'h0};
    vecs[1]  = '{4'b0000, 4'b0000, 32'h0,  4'h0, 32'h0,        4'b0000, 4'b0001, 32'hDEADBEEF};
    vecs[2]  = '{4'b0010, 4'b0010, 32'h20, 4'h5, 32'hAABBCCDD, 4'b0010, 4'b0000, 32'h0};
    vecs[3]  = '{4'b0010, 4'b0000, 32'h20, 4'hF, 32'h0,        4'b0010, 4'b0010, 32'h0};
    vecs[4]  = '{4'b0000, 4'b0000, 32'h0,  4'h0, 32'h0,        4'b0000, 4'b0010, 32'h00BB00DD};
    vecs[5]  = '{4'b1111, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b0100, 4'b0000, 32'h0};
    vecs[6]  = '{4'b1111, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b1000, 4'b0100, 32'hDEADBEEF};
    vecs[7]  = '{4'b1111, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b0001, 4'b1000, 32'hDEADBEEF};
    vecs[8]  = '{4'b1111, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b0010, 4'b0001, 32'hDEADBEEF};
    vecs[9]  = '{4'b0100, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b0100, 4'b0010, 32'hDEADBEEF};
    vecs[10] = '{4'b1001, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b1000, 4'b0100, 32'hDEADBEEF};
    vecs[11] = '{4'b1001, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b0001, 4'b1000, 32'hDEADBEEF};
    vecs[12] = '{4'b0000, 4'b0000, 32'h0,  4'h0, 32'h0,        4'b0000, 4'b0001, 32'hDEADBEEF};
    vecs[13] = '{4'b1001, 4'b0000, 32'h10, 4'hF, 32'h0,        4'b1000, 4'b0000, 32'h0};
    vecs[14] = '{4'b0000, 4'b0000, 32'h0,  4'h0, 32'h0,        4'b0000, 4'b1000, 32'hDEADBEEF};
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; be = '0; wdata = '0;
`ifdef RAM_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_ram_en", 32'(ram_en), 32'h0);
    chk("reset_ram_addr", ram_addr, 32'h0);
    // all four requesting continuously from reset
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 4'b0000, 32'h10, 4'hF, 32'h0);
      chk("rr_order_gnt", 32'(gnt), 32'(4'b0001 << (c % 4)));
      for (int i = 0; i < 4; i++) if (gnt[i]) cnt[i]++;
    end
    for (int i = 0; i < 4; i++) chk("rr_fair_count", 32'(cnt[i]), 32'd2);
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(vecs[k].req, vecs[k].we, vecs[k].addr, vecs[k].be, vecs[k].wdata);
      ea = (vecs[k].exp_gnt == 0) ? 32'h0 : vecs[k].addr | (32'(win(vecs[k].exp_gnt)) << 12);
      chk($sformatf("v%0d_gnt", k), 32'(gnt), 32'(vecs[k].exp_gnt));
      chk($sformatf("v%0d_ram_en", k), 32'(ram_en), 32'(|vecs[k].req));
      chk($sformatf("v%0d_ram_addr", k), ram_addr, ea);
      chk($sformatf("v%0d_ram_we", k), 32'(ram_we), 32'(|(vecs[k].exp_gnt & vecs[k].we)));
      chk($sformatf("v%0d_ram_be", k), 32'(ram_be), (vecs[k].exp_gnt == 0) ? 32'h0 : 32'(vecs[k].be));
      chk($sformatf("v%0d_ram_wdata", k), ram_wdata, (vecs[k].exp_gnt == 0) ? 32'h0 : vecs[k].wdata);
      chk($sformatf("v%0d_rvalid", k), 32'(rvalid), 32'(vecs[k].exp_rv));
      if (vecs[k].exp_rv != 0) chk($sformatf("v%0d_rdata", k), rdata, vecs[k].exp_rdata);
    end
    // reset in the cycle after a grant drops the pending response
    drive(4'b0100, 4'b0000, 32'h10, 4'hF, 32'h0);
    chk("mid_reset_gnt", 32'(gnt), 32'h4);
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("mid_reset_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1100, 4'b0000, 32'h10, 4'hF, 32'h0);
    chk("post_reset_gnt", 32'(gnt), 32'h4);
    drive(4'b0000, 4'b0000, 32'h0, 4'h0, 32'h0);
    chk("post_reset_rvalid", 32'(rvalid), 32'h4);
    chk("post_reset_rdata", rdata, 32'hDEADBEEF);
`ifdef RAM_ARB_STATS_EN
    do_reset();
    for (int c = 0; c < 9; c++) drive(4'b0111, 4'b0000, 32'h10, 4'hF, 32'h0);
    drive(4'b0000, 4'b0000, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) chk("stat_wait", stat_wait[i*32 +: 32], (i < 3) ? 32'd6 : 32'd0);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) chk("stat_clr", stat_wait[i*32 +: 32], 32'd0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
